spi_responder_regs: RTL

- SPI mode-0 slave (responder) for the spi0 bus. It is the far end of the SoC's SPI master.
- Implements a MAX3421E-style command-byte protocol over a 32x8 register bank.
- Used as an on-FPGA stand-in for the USB controller during bring-up, and as a loopback target in simulation.
- A local-side port lets fabric logic read and write the same registers; the block also strobes completed SPI writes out to fabric.

---
 rtl/spi_resp_pkg.sv | 16 +
 rtl/spi_sync_edge.sv | 30 +++
 rtl/spi_responder_regs.sv | 177 +++++++++++++++++
 3 files changed

// File: rtl/spi_resp_pkg.sv
// Shared types and command-byte field positions for the SPI register responder.
package spi_resp_pkg;

  localparam int unsigned DATA_W       = 8;
  localparam int unsigned CMD_ADDR_MSB = 7;
  localparam int unsigned CMD_ADDR_LSB = 3;
  localparam int unsigned CMD_DIR_BIT  = 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CMD  = 2'd1,
    WR   = 2'd2,
    RD   = 2'd3
  } state_e;

endpackage

// File: rtl/spi_sync_edge.sv
// Multi-flop synchronizer for one asynchronous pin, with rise/fall detect on the
// last two synchronized samples.
module spi_sync_edge #(
  parameter int unsigned STAGES  = 2,
  parameter bit          RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic din,
  output logic rise_c,
  output logic fall_c
);

  logic [STAGES-1:0] chain_q;
  logic              prev_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      chain_q <= {STAGES{RST_VAL}};
      prev_q  <= RST_VAL;
    end else begin
      chain_q <= {chain_q[STAGES-2:0], din};
      prev_q  <= chain_q[STAGES-1];
    end
  end

  assign rise_c =  chain_q[STAGES-1] & ~prev_q;
  assign fall_c = ~chain_q[STAGES-1] &  prev_q;

endmodule

// File: rtl/spi_responder_regs.sv
// SPI mode-0 responder exposing a register bank through a command-byte protocol,
// with a local-side read/write port and write/read strobes toward the fabric.
module spi_responder_regs
  import spi_resp_pkg::*;
#(
  parameter int unsigned ADDR_W      = 5,
  parameter int unsigned DATA_W      = spi_resp_pkg::DATA_W,
  parameter int unsigned STATUS_ADDR = 25,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic              clk_clk,
  input  logic              reset_reset_n,
  input  logic              spi0_SCLK,
  input  logic              spi0_MOSI,
  input  logic              spi0_SS_n,
  output logic              spi0_MISO,
  output logic              miso_oe,
  input  logic [ADDR_W-1:0] loc_addr,
  input  logic [DATA_W-1:0] loc_wdata,
  input  logic              loc_we,
  output logic [DATA_W-1:0] loc_rdata,
  output logic              wr_strobe,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [DATA_W-1:0] wr_data,
  output logic              rd_strobe,
  output logic              busy
);

  localparam int unsigned       NREGS      = 1 << ADDR_W;
  localparam int unsigned       CNT_W      = 3;
  localparam logic [ADDR_W-1:0] STATUS_IDX = ADDR_W'(STATUS_ADDR);

  logic sclk_rise_c, sclk_fall_c, ss_rise_c, ss_fall_c;
  logic [SYNC_STAGES-1:0] mosi_q;
  logic                   mosi_s;

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   bit_cnt_q;
  logic [DATA_W-1:0]  rx_q, tx_q, rx_next_c;
  logic [ADDR_W-1:0]  addr_q, cmd_addr_c;
  logic               cmd_dir_c, byte_done_q, last_bit_c, spi_we_c;
  logic [DATA_W-1:0]  regs_q [NREGS];

  spi_sync_edge #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sclk_sync (
    .clk    (clk_clk),
    .rst_n  (reset_reset_n),
    .din    (spi0_SCLK),
    .rise_c (sclk_rise_c),
    .fall_c (sclk_fall_c)
  );

  // SS_n idles high, so its chain resets high to avoid a false select at reset release.
  spi_sync_edge #(.STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_ss_sync (
    .clk    (clk_clk),
    .rst_n  (reset_reset_n),
    .din    (spi0_SS_n),
    .rise_c (ss_rise_c),
    .fall_c (ss_fall_c)
  );

  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) mosi_q <= '0;
    else                mosi_q <= {mosi_q[SYNC_STAGES-2:0], spi0_MOSI};
  end

  assign mosi_s     = mosi_q[SYNC_STAGES-1];
  assign rx_next_c  = {rx_q[DATA_W-2:0], mosi_s};
  assign cmd_addr_c = ADDR_W'(rx_next_c[CMD_ADDR_MSB:CMD_ADDR_LSB]);
  assign cmd_dir_c  = rx_next_c[CMD_DIR_BIT];
  assign last_bit_c = sclk_rise_c && !ss_rise_c && (state_q != IDLE) &&
                      (bit_cnt_q == CNT_W'(7));
  assign spi_we_c   = last_bit_c && (state_q == WR);

  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) state_q <= IDLE;
    else                state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (ss_rise_c) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE:    if (ss_fall_c) state_d = CMD;
        CMD:     if (last_bit_c) state_d = cmd_dir_c ? WR : RD;
        default: state_d = state_q;
      endcase
    end
  end

  // Serial datapath: shift in on SCLK rise, shift out on SCLK fall.
  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      bit_cnt_q   <= '0;
      rx_q        <= '0;
      tx_q        <= '0;
      addr_q      <= '0;
      byte_done_q <= 1'b0;
      spi0_MISO   <= 1'b0;
      miso_oe     <= 1'b0;
      wr_strobe   <= 1'b0;
      wr_addr     <= '0;
      wr_data     <= '0;
      rd_strobe   <= 1'b0;
      busy        <= 1'b0;
    end else begin
      wr_strobe <= 1'b0;
      rd_strobe <= 1'b0;
      busy      <= (state_d != IDLE);
      if (ss_rise_c) begin
        bit_cnt_q   <= '0;
        byte_done_q <= 1'b0;
        spi0_MISO   <= 1'b0;
        miso_oe     <= 1'b0;
      end else if (state_q == IDLE) begin
        if (ss_fall_c) begin
          tx_q        <= regs_q[STATUS_IDX];
          spi0_MISO   <= regs_q[STATUS_IDX][DATA_W-1];
          miso_oe     <= 1'b1;
          bit_cnt_q   <= '0;
          byte_done_q <= 1'b0;
        end
      end else if (sclk_rise_c) begin
        rx_q      <= rx_next_c;
        bit_cnt_q <= bit_cnt_q + CNT_W'(1);
        if (last_bit_c) begin
          byte_done_q <= 1'b1;
          case (state_q)
            CMD: begin
              addr_q <= cmd_addr_c;
              if (!cmd_dir_c) begin
                tx_q      <= regs_q[cmd_addr_c];
                rd_strobe <= 1'b1;
              end
            end
            WR: begin
              wr_strobe <= 1'b1;
              wr_addr   <= addr_q;
              wr_data   <= rx_next_c;
            end
            RD: begin
              tx_q      <= regs_q[addr_q];
              rd_strobe <= 1'b1;
            end
            default: ;
          endcase
        end
      end else if (sclk_fall_c) begin
        // The first fall after a byte boundary presents the freshly loaded MSB.
        if (byte_done_q) begin
          spi0_MISO   <= tx_q[DATA_W-1];
          byte_done_q <= 1'b0;
        end else begin
          spi0_MISO <= tx_q[DATA_W-2];
          tx_q      <= {tx_q[DATA_W-2:0], 1'b0};
        end
      end
    end
  end

  // SPI write is applied after the local write so it wins on an address collision.
  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      for (int unsigned i = 0; i < NREGS; i++) regs_q[i] <= '0;
    end else begin
      if (loc_we)   regs_q[loc_addr] <= loc_wdata;
      if (spi_we_c) regs_q[addr_q]   <= rx_next_c;
    end
  end

  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) loc_rdata <= '0;
    else                loc_rdata <= regs_q[loc_addr];
  end

endmodule
